// File: rtl/fp_operand_sequencer.sv
// fp_operand_sequencer: handshaked FP operand-pair source (table/random; FP_SEQ_SPECIALS_EN adds specials mode)
module fp_operand_sequencer #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int DEPTH = 8,
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [1:0]               i_mode,
  input  logic [15:0]              i_count,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [EXP_W+MAN_W:0]     o_a,
  output logic [EXP_W+MAN_W:0]     o_b,
  output logic [$clog2(DEPTH)-1:0] o_idx,
  output logic                     o_busy,
  output logic                     o_done
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int IW = $clog2(DEPTH);
  localparam int IX = IW < 2 ? 2 : IW;
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam logic [31:0] SEED0 = SEED == 32'h0 ? 32'h1 : SEED;
  localparam logic [31:0] TAPS = 32'h8020_0003;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st;
  logic [1:0] md;
  logic [15:0] cnt, xfer;
  logic [IX-1:0] idx, idx_nx;
  logic [31:0] lfsr, lfsr_nx;
  logic xf, last, rnd, spc;
  function automatic logic [W-1:0] to_fp(input int n);
    int p;
    p = 0;
    for (int i = 0; i < 32; i++) if (n[i]) p = i;
    return {1'b0, EXP_W'(BIAS + p), MAN_W'(n << (MAN_W - p))};
  endfunction
  function automatic logic [W-1:0] fix(input logic [W-1:0] v);
    return (&v[W-2:MAN_W] || ~|v[W-2:MAN_W]) ? {v[W-1], EXP_W'(BIAS), v[MAN_W-1:0]} : v;
  endfunction
`ifdef FP_SEQ_SPECIALS_EN
  function automatic logic [2*W-1:0] spec(input logic [1:0] k);
    logic [W-1:0] pinf, qnan, sgn;
    pinf = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    qnan = pinf | (W'(1) << (MAN_W - 1));
    sgn = W'(1) << (W - 1);
    return k == 2'd0 ? {W'(0), sgn} :
           k == 2'd1 ? {pinf, pinf | sgn} :
           k == 2'd2 ? {qnan, qnan} :
                       {W'(1), 1'b0, EXP_W'(BIAS), {MAN_W{1'b0}}};
  endfunction
`endif
  function automatic logic [2*W-1:0] pair(input logic [1:0] m, input logic [IX-1:0] k, input logic [W-1:0] r);
    logic [W-1:0] rv;
    for (int i = 0; i < W; i++) rv[i] = r[W-1-i];
`ifdef FP_SEQ_SPECIALS_EN
    if (m == 2'd2) return spec(k[1:0]);
`endif
    return m == 2'd1 ? {fix(r), fix(rv)} : {to_fp(int'(k) + 1), to_fp(DEPTH - int'(k))};
  endfunction
  always_comb begin
    xf = o_valid & i_ready;
    last = xfer == cnt - 16'd1;
    rnd = md == 2'd1;
`ifdef FP_SEQ_SPECIALS_EN
    spc = md == 2'd2;
`else
    spc = 1'b0;
`endif
    idx_nx = rnd ? '0 : idx == (spc ? IX'(3) : IX'(DEPTH - 1)) ? '0 : idx + 1'b1;
    lfsr_nx = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);
  end
  assign o_idx = idx[IW-1:0];
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st <= IDLE;
      md <= 2'd0;
      cnt <= 16'd0;
      xfer <= 16'd0;
      idx <= '0;
      lfsr <= SEED0;
      o_valid <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_a <= '0;
      o_b <= '0;
    end else begin
      o_done <= 1'b0;
      case (st)
        IDLE: if (i_start && i_count != 16'd0) begin
          st <= RUN;
          md <= i_mode;
          cnt <= i_count;
          xfer <= 16'd0;
          idx <= '0;
          {o_a, o_b} <= pair(i_mode, '0, lfsr[W-1:0]);
          o_valid <= 1'b1;
          o_busy <= 1'b1;
        end
        RUN: if (xf) begin
          if (rnd) lfsr <= lfsr_nx;
          if (last) begin
            st <= DONE;
            o_valid <= 1'b0;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else begin
            xfer <= xfer + 16'd1;
            idx <= idx_nx;
            {o_a, o_b} <= pair(md, idx_nx, rnd ? lfsr_nx[W-1:0] : lfsr[W-1:0]);
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_operand_sequencer.sv
// tb_fp_operand_sequencer: directed self-checking bench for fp_operand_sequencer
module tb_fp_operand_sequencer;
  logic clk, rst, start, ready, valid, busy, done;
  logic [1:0] mode;
  logic [15:0] count;
  logic [31:0] a, b;
  logic [2:0] idx;
  logic s_start, s_valid, s_busy, s_done;
  logic [1:0] s_mode;
  logic [15:0] s_count;
  logic [15:0] s_a, s_b;
  logic [2:0] s_idx;
  int checks = 0;
  int errors = 0;
  logic [31:0] m, first_a, first_b;
  fp_operand_sequencer dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_count(count), .i_ready(ready),
    .o_valid(valid), .o_a(a), .o_b(b), .o_idx(idx), .o_busy(busy), .o_done(done)
  );
  fp_operand_sequencer #(.EXP_W(5), .MAN_W(10)) dut_h (
    .i_clk(clk), .i_rst(rst), .i_start(s_start), .i_mode(s_mode), .i_count(s_count), .i_ready(1'b1),
    .o_valid(s_valid), .o_a(s_a), .o_b(s_b), .o_idx(s_idx), .o_busy(s_busy), .o_done(s_done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] fv(input int n);
    case (n)
      1: return 32'h3F80_0000;
      2: return 32'h4000_0000;
      3: return 32'h4040_0000;
      4: return 32'h4080_0000;
      5: return 32'h40A0_0000;
      6: return 32'h40C0_0000;
      7: return 32'h40E0_0000;
      default: return 32'h4100_0000;
    endcase
  endfunction
  function automatic logic [31:0] lnext(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction
  function automatic logic [31:0] rfix(input logic [31:0] v);
    return (v[30:23] == 8'h00 || v[30:23] == 8'hFF) ? {v[31], 8'h7F, v[22:0]} : v;
  endfunction
  function automatic logic [31:0] rev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [1:0] md, input logic [15:0] n);
    start = 1'b1;
    mode = md;
    count = n;
    step;
    start = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1; start = 1'b0; ready = 1'b1; mode = 2'd0; count = 16'd0;
    s_start = 1'b0; s_mode = 2'd0; s_count = 16'd0;
    step;
    step;
    checks++;
    if ({valid, busy, done} !== 3'b000 || a !== 32'h0 || b !== 32'h0 || idx !== 3'd0) begin
      errors++;
      $display("FAIL reset: v/b/d=%b%b%b a=%h b=%h idx=%0d, want 000 0 0 0", valid, busy, done, a, b, idx);
    end
    checks++;
    if ({s_valid, s_busy, s_done} !== 3'b000 || s_a !== 16'h0 || s_b !== 16'h0) begin
      errors++;
      $display("FAIL reset_half: v/b/d=%b%b%b a=%h b=%h, want 000 0 0", s_valid, s_busy, s_done, s_a, s_b);
    end
    rst = 1'b0;
    step;
  endtask
  task automatic test_table_basic;
    go(2'd0, 16'd2);
    checks++;
    if (valid !== 1'b1 || busy !== 1'b1 || a !== 32'h3F80_0000 || b !== 32'h4100_0000 || idx !== 3'd0) begin
      errors++;
      $display("FAIL table_pair1: v=%b busy=%b a=%h b=%h idx=%0d, want 1 1 3f800000 41000000 0", valid, busy, a, b, idx);
    end
    step;
    checks++;
    if (valid !== 1'b1 || a !== 32'h4000_0000 || b !== 32'h40E0_0000 || idx !== 3'd1) begin
      errors++;
      $display("FAIL table_pair2: v=%b a=%h b=%h idx=%0d, want 1 40000000 40e00000 1", valid, a, b, idx);
    end
    step;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL table_done: v/b/d=%b%b%b, want 001", valid, busy, done);
    end
    step;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b, want 0", done);
    end
  endtask
  task automatic test_table_wrap;
    go(2'd0, 16'd10);
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (valid !== 1'b1 || idx !== 3'(j % 8) || a !== fv(j % 8 + 1) || b !== fv(8 - j % 8)) begin
        errors++;
        $display("FAIL wrap_pair%0d: v=%b idx=%0d a=%h b=%h, want 1 %0d %h %h", j, valid, idx, a, b, j % 8, fv(j % 8 + 1), fv(8 - j % 8));
      end
      step;
    end
    checks++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_done: done=%b v=%b, want 1 0", done, valid);
    end
    step;
  endtask
  task automatic test_backpressure;
    go(2'd0, 16'd6);
    for (int j = 0; j < 6; j++) begin
      if (j == 2) begin
        ready = 1'b0;
        repeat (5) begin
          step;
          checks++;
          if (valid !== 1'b1 || idx !== 3'(j) || a !== fv(j + 1) || b !== fv(8 - j)) begin
            errors++;
            $display("FAIL stall_hold: v=%b idx=%0d a=%h b=%h, want 1 %0d %h %h", valid, idx, a, b, j, fv(j + 1), fv(8 - j));
          end
        end
        ready = 1'b1;
      end
      checks++;
      if (valid !== 1'b1 || idx !== 3'(j) || a !== fv(j + 1) || b !== fv(8 - j)) begin
        errors++;
        $display("FAIL bp_pair%0d: v=%b idx=%0d a=%h b=%h, want 1 %0d %h %h", j, valid, idx, a, b, j, fv(j + 1), fv(8 - j));
      end
      step;
    end
    checks++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: done=%b v=%b, want 1 0", done, valid);
    end
    step;
  endtask
  task automatic test_random;
    rst = 1'b1;
    step;
    rst = 1'b0;
    step;
    m = 32'hACE1_2468;
    first_a = rfix(m);
    first_b = rfix(rev(m));
    go(2'd1, 16'd1000);
    for (int j = 0; j < 1000; j++) begin
      checks++;
      if (valid !== 1'b1 || idx !== 3'd0 || a !== rfix(m) || b !== rfix(rev(m))) begin
        errors++;
        $display("FAIL rand_pair%0d: v=%b idx=%0d a=%h b=%h, want 1 0 %h %h", j, valid, idx, a, b, rfix(m), rfix(rev(m)));
      end
      checks++;
      if (a[30:23] === 8'h00 || a[30:23] === 8'hFF || b[30:23] === 8'h00 || b[30:23] === 8'hFF) begin
        errors++;
        $display("FAIL rand_exp%0d: exps=%h/%h, want neither 00 nor ff", j, a[30:23], b[30:23]);
      end
      step;
      m = lnext(m);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL rand_done: done=%b, want 1", done);
    end
    step;
    go(2'd1, 16'd5);
    checks++;
    if (a !== rfix(m) || b !== rfix(rev(m))) begin
      errors++;
      $display("FAIL rand_continue: a=%h b=%h, want %h %h", a, b, rfix(m), rfix(rev(m)));
    end
    step;
    step;
    rst = 1'b1;
    step;
    checks++;
    if ({valid, busy, done} !== 3'b000 || a !== 32'h0 || b !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: v/b/d=%b%b%b a=%h b=%h, want 000 0 0", valid, busy, done, a, b);
    end
    rst = 1'b0;
    go(2'd1, 16'd1);
    checks++;
    if (valid !== 1'b1 || a !== first_a || b !== first_b) begin
      errors++;
      $display("FAIL rand_restart: v=%b a=%h b=%h, want 1 %h %h", valid, a, b, first_a, first_b);
    end
    step;
    step;
  endtask
  task automatic test_mode2;
`ifdef FP_SEQ_SPECIALS_EN
    logic [31:0] ea, eb;
    go(2'd2, 16'd5);
    for (int j = 0; j < 5; j++) begin
      ea = (j % 4 == 0) ? 32'h0000_0000 : (j % 4 == 1) ? 32'h7F80_0000 : (j % 4 == 2) ? 32'h7FC0_0000 : 32'h0000_0001;
      eb = (j % 4 == 0) ? 32'h8000_0000 : (j % 4 == 1) ? 32'hFF80_0000 : (j % 4 == 2) ? 32'h7FC0_0000 : 32'h3F80_0000;
      checks++;
      if (valid !== 1'b1 || idx !== 3'(j % 4) || a !== ea || b !== eb) begin
        errors++;
        $display("FAIL spec_pair%0d: v=%b idx=%0d a=%h b=%h, want 1 %0d %h %h", j, valid, idx, a, b, j % 4, ea, eb);
      end
      step;
    end
`else
    go(2'd2, 16'd3);
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (valid !== 1'b1 || idx !== 3'(j) || a !== fv(j + 1) || b !== fv(8 - j)) begin
        errors++;
        $display("FAIL mode2_pair%0d: v=%b idx=%0d a=%h b=%h, want 1 %0d %h %h", j, valid, idx, a, b, j, fv(j + 1), fv(8 - j));
      end
      step;
    end
`endif
    step;
    go(2'd3, 16'd2);
    for (int j = 0; j < 2; j++) begin
      checks++;
      if (valid !== 1'b1 || idx !== 3'(j) || a !== fv(j + 1) || b !== fv(8 - j)) begin
        errors++;
        $display("FAIL mode3_pair%0d: v=%b idx=%0d a=%h b=%h, want 1 %0d %h %h", j, valid, idx, a, b, j, fv(j + 1), fv(8 - j));
      end
      step;
    end
    step;
  endtask
  task automatic test_ignored;
    go(2'd0, 16'd0);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_count: busy=%b v=%b, want 0 0", busy, valid);
    end
    step;
    go(2'd0, 16'd3);
    ready = 1'b0;
    start = 1'b1;
    mode = 2'd1;
    count = 16'd7;
    step;
    step;
    start = 1'b0;
    ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (valid !== 1'b1 || idx !== 3'(j) || a !== fv(j + 1)) begin
        errors++;
        $display("FAIL run_start_pair%0d: v=%b idx=%0d a=%h, want 1 %0d %h", j, valid, idx, a, j, fv(j + 1));
      end
      step;
    end
    checks++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL run_start_len: done=%b v=%b, want 1 0", done, valid);
    end
    start = 1'b1;
    mode = 2'd0;
    count = 16'd1;
    step;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL done_start: busy=%b v=%b done=%b, want 0 0 0", busy, valid, done);
    end
    step;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || valid !== 1'b1 || a !== 32'h3F80_0000) begin
      errors++;
      $display("FAIL restart_after_done: busy=%b v=%b a=%h, want 1 1 3f800000", busy, valid, a);
    end
    step;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL single_done: done=%b, want 1", done);
    end
    step;
  endtask
  task automatic test_small;
    s_mode = 2'd0;
    s_count = 16'd1;
    s_start = 1'b1;
    step;
    s_start = 1'b0;
    checks++;
    if (s_valid !== 1'b1 || s_a !== 16'h3C00 || s_b !== 16'h4800 || s_idx !== 3'd0) begin
      errors++;
      $display("FAIL half_entry0: v=%b a=%h b=%h idx=%0d, want 1 3c00 4800 0", s_valid, s_a, s_b, s_idx);
    end
    step;
    checks++;
    if (s_done !== 1'b1 || s_valid !== 1'b0) begin
      errors++;
      $display("FAIL half_done: done=%b v=%b, want 1 0", s_done, s_valid);
    end
    step;
  endtask
  initial begin
    test_reset;
    test_table_basic;
    test_table_wrap;
    test_backpressure;
    test_mode2;
    test_ignored;
    test_small;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_operand_sequencer.md
# fp_operand_sequencer

Parametrised, handshaked operand-pair source for the floating-point unit. On a start request it emits a programmable number of (A, B) operand pairs in IEEE-754-style format of configurable width, drawn from a deterministic integer table, a pseudo-random generator, or an optional special-value set. It sits in front of the FPU datapath in bring-up and self-test builds and replaces fixed per-select constant lookup.

## Interface
- EXP_W, 8: exponent field width; legal range 2..11.
- MAN_W, 23: mantissa field width; legal range 2..52. Also requires 1+EXP_W+MAN_W ≤ 32.
- DEPTH, 8: table entries; power of two; legal range 2..2^MAN_W.
- SEED, 32'hACE1_2468: LFSR reset value. A zero seed is replaced by 32'h1.
- Derived: W = 1+EXP_W+MAN_W; IW = clog2(DEPTH); BIAS = 2^(EXP_W-1)-1.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  request a burst; sampled in IDLE only.
- i_mode  in  2  0 = table, 1 = random, 2 = specials, 3 = reserved; latched at start.
- i_count  in  16  number of pairs in the burst; latched at start.
- i_ready  in  1  consumer accepts the current pair.
- o_valid  out  1  o_a/o_b hold a valid pair.
- o_a, o_b  out  W  operand pair.
- o_idx  out  IW  table/special index of the current pair; 0 in random mode.
- o_busy  out  1  high in RUN.
- o_done  out  1  one-cycle pulse after the last transfer.

## Operation
- FSM has three states: IDLE, RUN, DONE.
  - IDLE → RUN on i_start=1 with i_count≠0. This latches mode and count, and clears index and transfer counter.
  - i_start with i_count=0 is ignored.
  - RUN → DONE on the transfer that makes the transfer counter equal the latched count.
  - DONE → IDLE unconditionally after one cycle.
- A transfer occurs when o_valid & i_ready.
- i_start is ignored outside IDLE, including in DONE.
- Table mode, entry k:
  - o_a = float(k+1); o_b = float(DEPTH−k).
  - Each value is an exact normalised encoding: sign 0, exponent BIAS+floor(log2 n), mantissa = n's bits below the MSB, left-aligned in MAN_W.
  - The index increments per transfer and wraps DEPTH−1 → 0.
- Random mode:
  - 32-bit Galois LFSR, taps 32'h8020_0003, advanced only on a transfer.
  - o_a = state[W−1:0]; o_b = bit-reversed state[W−1:0].
  - Exponent fix-up: if the exponent field is all zeros or all ones, replace it with BIAS. Random pairs are therefore always normal and finite.
  - The LFSR is not reseeded at start; it continues across bursts.
- Specials mode: see Configuration.
- Mode 3 behaves as table mode.

## Timing
- Reset values:
  - FSM in IDLE.
  - o_valid=0, o_busy=0, o_done=0, o_idx=0, o_a=0, o_b=0.
  - LFSR = SEED, or 1 if SEED is zero.
- All outputs are registered.
- o_valid rises the cycle after start is accepted, and stays high through RUN until the final transfer.
- While o_valid & !i_ready, o_a, o_b and o_idx hold stable.
- The next pair is presented the cycle after a transfer. Back-to-back transfers give a throughput of one pair per cycle.
- After the final transfer:
  - o_valid and o_busy drop in the next cycle.
  - o_done=1 for exactly that cycle.
  - A new start is accepted the cycle after o_done.
- i_rst mid-burst returns to IDLE next edge; outputs go to their reset values and the LFSR reloads. No o_done is produced.
- With i_count=65535, the 16-bit counter must not overflow; the burst ends exactly at 65535 transfers.

## Configuration
- FP_SEQ_SPECIALS_EN defined: mode 2 cycles a 4-entry special set; the index wraps 3 → 0.
  - o_a: +0, +inf, quiet NaN (exponent all ones, mantissa MSB only), minimum positive denormal (mantissa 1).
  - o_b: −0, −inf, quiet NaN, +1.0.
- FP_SEQ_SPECIALS_EN undefined: mode 2 behaves exactly as table mode, and no special-value logic is built.

## Test plan
- Defaults, table mode, i_count=2, i_ready=1:
  - Pair 1: o_a=0x3F800000, o_b=0x41000000.
  - Pair 2: o_a=0x40000000, o_b=0x40E00000.
  - o_done pulses one cycle after the last transfer.
- Table mode, i_count=10: o_idx runs 0..7,0,1, and the 9th pair repeats 0x3F800000/0x41000000.
- Backpressure: hold i_ready=0 for 5 cycles mid-burst -> o_a/o_b/o_idx stable, o_valid high, and no pair is lost or duplicated.
- Random mode, 1000 pairs, checked against a reference LFSR model:
  - No exponent field is 0x00 or 0xFF.
  - A reset mid-burst followed by restart reproduces the first pair.
- Specials mode with macro defined, i_count=5: o_a = 0x00000000, 0x7F800000, 0x7FC00000, 0x00000001, 0x00000000; o_b = 0x80000000, 0xFF800000, 0x7FC00000, 0x3F800000, 0x80000000.
- Ignored starts:
  - i_start with i_count=0 -> stays IDLE.
  - i_start during RUN -> burst length unchanged.
  - EXP_W=5/MAN_W=10 table entry 0 -> o_a=0x3C00.
